// File: rtl/ats_alarm_event_queue.sv
// Alarm event queue: turns rising edges on the alarm-finished bus into
// timestamped events, buffers them in a FIFO and hands them out over valid/ready.
module ats_alarm_event_queue #(
    parameter int NUM_ALARMS = 24,
    parameter int ID_W       = 5,
    parameter int TS_W       = 16,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_ALARMS-1:0]      finished,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [ID_W-1:0]            evt_id,
    output logic [TS_W-1:0]            evt_time,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [NUM_ALARMS-1:0]      pending,
    output logic                       drop,
    input  logic                       drop_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_ALARMS-1:0] prev_finished;
    logic [NUM_ALARMS-1:0] rise;
    logic [NUM_ALARMS-1:0] pending_q;
    logic [NUM_ALARMS-1:0] enq_onehot;
    logic [NUM_ALARMS-1:0] lost;
    logic [TS_W-1:0]       ts;
    logic [ID_W-1:0]       mem_id   [DEPTH];
    logic [TS_W-1:0]       mem_time [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  drop_q;
    logic [ID_W-1:0]       enq_idx;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign rise = finished & ~prev_finished;
    assign full = (count == CNT_W'(DEPTH));
    // Room is judged on the count at the start of the cycle; a pop does not
    // make space for a push in the same cycle.
    assign push = (|pending_q) & ~full;
    assign pop  = (count != '0) & evt_ready;

    // Lowest set pending index wins the single enqueue slot.
    always_comb begin
        enq_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enq_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        enq_onehot = '0;
        if (push) begin
            enq_onehot = NUM_ALARMS'(1) << enq_idx;
        end
    end

    // A re-rise on an alarm that is pending and not leaving this cycle is lost.
    assign lost = rise & pending_q & ~enq_onehot;

    always_ff @(posedge clk) begin
        prev_finished <= finished;
        if (reset) begin
            ts        <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            ts        <= ts + 1'b1;
            pending_q <= rise | (pending_q & ~enq_onehot);
            if (|lost) begin
                drop_q <= 1'b1;
            end else if (drop_clr) begin
                drop_q <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_id[wr_ptr]   <= enq_idx;
            mem_time[wr_ptr] <= ts;
        end
    end

    assign evt_valid  = (count != '0);
    assign evt_id     = evt_valid ? mem_id[rd_ptr]   : '0;
    assign evt_time   = evt_valid ? mem_time[rd_ptr] : '0;
    assign fifo_count = count;
    assign pending    = pending_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_ats_alarm_event_queue.sv
// Directed bench for ats_alarm_event_queue: inputs change and outputs are
// sampled 1ns after each rising edge; a local timestamp model tracks ts.
module tb_ats_alarm_event_queue;

    logic        clk;
    logic        reset;
    logic [23:0] finished;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_id;
    logic [15:0] evt_time;
    logic [3:0]  fifo_count;
    logic [23:0] pending;
    logic        drop;
    logic        drop_clr;

    int          checks;
    int          failures;
    logic [15:0] tb_ts;
    logic [15:0] t;

    ats_alarm_event_queue dut (
        .clk        (clk),
        .reset      (reset),
        .finished   (finished),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_time   (evt_time),
        .fifo_count (fifo_count),
        .pending    (pending),
        .drop       (drop),
        .drop_clr   (drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (reset) tb_ts = '0;
        else       tb_ts = tb_ts + 16'd1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] bp_ids [10];
        bp_ids = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd20, 5'd23};
        checks    = 0;
        failures  = 0;
        tb_ts     = '0;
        reset     = 1'b1;
        finished  = '0;
        evt_ready = 1'b0;
        drop_clr  = 1'b0;
        repeat (3) tick();

        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id",    32'(evt_id), 32'd0);
        check("rst_time",  32'(evt_time), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_pend",  32'(pending), 32'd0);
        check("rst_drop",  32'(drop), 32'd0);

        // Single event: first non-reset edge is edge 0, finished[5] up before edge 10.
        reset = 1'b0;
        repeat (10) tick();
        finished[5] = 1'b1;
        tick();
        check("single_pend", 32'(pending), 32'h20);
        tick();
        finished[5] = 1'b0;
        check("single_valid", 32'(evt_valid), 32'd1);
        check("single_id",    32'(evt_id), 32'd5);
        check("single_time",  32'(evt_time), 32'd11);
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_pend0", 32'(pending), 32'd0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("single_pop_count", 32'(fifo_count), 32'd0);
        check("single_pop_valid", 32'(evt_valid), 32'd0);

        // Simultaneous rise of 0, 3, 17.
        finished = 24'h020009;
        tick();
        check("sim_pend_a", 32'(pending), 32'h020009);
        t = tb_ts;
        tick();
        finished = '0;
        check("sim_pend_b", 32'(pending), 32'h020008);
        tick();
        check("sim_pend_c", 32'(pending), 32'h020000);
        tick();
        check("sim_pend_d", 32'(pending), 32'd0);
        check("sim_count", 32'(fifo_count), 32'd3);
        evt_ready = 1'b1;
        check("sim_id0", 32'(evt_id), 32'd0);
        check("sim_t0",  32'(evt_time), 32'(t));
        tick();
        check("sim_id1", 32'(evt_id), 32'd3);
        check("sim_t1",  32'(evt_time), 32'(16'(t + 16'd1)));
        tick();
        check("sim_id2", 32'(evt_id), 32'd17);
        check("sim_t2",  32'(evt_time), 32'(16'(t + 16'd2)));
        tick();
        evt_ready = 1'b0;
        check("sim_empty", 32'(fifo_count), 32'd0);

        // Full backpressure with ten distinct alarms.
        finished = 24'h905556;
        tick();
        tick();
        finished = '0;
        repeat (8) tick();
        check("bp_count", 32'(fifo_count), 32'd8);
        check("bp_pend",  32'(pending), 32'h900000);
        check("bp_drop",  32'(drop), 32'd0);
        evt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_valid%0d", k), 32'(evt_valid), 32'd1);
            check($sformatf("bp_id%0d", k), 32'(evt_id), 32'(bp_ids[k]));
            tick();
        end
        evt_ready = 1'b0;
        check("bp_empty", 32'(fifo_count), 32'd0);
        check("bp_pend0", 32'(pending), 32'd0);

        // Drop handling with the FIFO held full.
        finished = 24'h00FF00;
        tick();
        tick();
        finished = '0;
        repeat (8) tick();
        check("drop_full", 32'(fifo_count), 32'd8);
        finished[2] = 1'b1;
        tick();
        tick();
        finished[2] = 1'b0;
        check("drop_pend1", 32'(pending), 32'h4);
        check("drop_none",  32'(drop), 32'd0);
        repeat (4) tick();
        finished[2] = 1'b1;
        tick();
        check("drop_set",   32'(drop), 32'd1);
        check("drop_pend2", 32'(pending), 32'h4);
        tick();
        finished[2] = 1'b0;
        tick();
        drop_clr    = 1'b1;
        finished[2] = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("drop_set_wins", 32'(drop), 32'd1);
        tick();
        finished[2] = 1'b0;
        tick();
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("drop_clr", 32'(drop), 32'd0);
        check("drop_pend3", 32'(pending), 32'h4);
        check("drop_count", 32'(fifo_count), 32'd8);
        evt_ready = 1'b1;
        repeat (12) tick();
        evt_ready = 1'b0;
        check("drop_drain_count", 32'(fifo_count), 32'd0);
        check("drop_drain_pend",  32'(pending), 32'd0);

        // Timestamp wrap: alarm 9 enqueues at 0xFFFF, alarm 11 at 0x0000.
        while (tb_ts != 16'hFFFE) tick();
        finished[9]  = 1'b1;
        finished[11] = 1'b1;
        tick();
        tick();
        finished = '0;
        tick();
        check("wrap_count", 32'(fifo_count), 32'd2);
        check("wrap_id0",   32'(evt_id), 32'd9);
        check("wrap_t0",    32'(evt_time), 32'hFFFF);
        evt_ready = 1'b1;
        tick();
        check("wrap_id1", 32'(evt_id), 32'd11);
        check("wrap_t1",  32'(evt_time), 32'h0000);
        tick();
        evt_ready = 1'b0;
        check("wrap_empty", 32'(fifo_count), 32'd0);

        // Reset with three queued events while finished[7] is held high.
        finished = 24'h000052;
        tick();
        tick();
        finished = '0;
        tick();
        tick();
        check("rst2_queued", 32'(fifo_count), 32'd3);
        finished[7] = 1'b1;
        reset       = 1'b1;
        tick();
        check("rst2_valid", 32'(evt_valid), 32'd0);
        check("rst2_id",    32'(evt_id), 32'd0);
        check("rst2_time",  32'(evt_time), 32'd0);
        check("rst2_count", 32'(fifo_count), 32'd0);
        check("rst2_pend",  32'(pending), 32'd0);
        check("rst2_drop",  32'(drop), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("rst2_noevt_valid", 32'(evt_valid), 32'd0);
        check("rst2_noevt_pend",  32'(pending), 32'd0);
        finished[7] = 1'b0;
        tick();
        finished[7] = 1'b1;
        tick();
        check("rst2_rerise_pend", 32'(pending), 32'h80);
        t = tb_ts;
        tick();
        check("rst2_rerise_valid", 32'(evt_valid), 32'd1);
        check("rst2_rerise_id",    32'(evt_id), 32'd7);
        check("rst2_rerise_time",  32'(evt_time), 32'(t));
        check("rst2_rerise_count", 32'(fifo_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
